// File: rtl/irq_ctrl_nsrc_v1.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl_nsrc_v1
//  Description : Interrupt controller for NUM_SRC peripheral event inputs.
//                It edge-detects each event and keeps a sticky pending flag
//                per source. Pending flags are masked by the SFR enable word.
//                The lowest enabled pending index is requested from the CPU
//                over an irq_req / irq_ack / irq_eoi handshake. The pending
//                word is mirrored to the SFR block via hw_up/hw_val.
//                Optional feature macro: IRQ_MISS_FLAG_EN adds sticky
//                missed-event flags (irq_miss port).
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl_nsrc_v1 #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 8,
    localparam int ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NUM_SRC-1:0]    src_event,
    input  logic [DATA_WIDTH-1:0] irq_en,
    input  logic [DATA_WIDTH-1:0] irq_clr,
    input  logic                  irq_ack,
    input  logic                  irq_eoi,
    output logic                  irq_req,
    output logic [ID_W-1:0]       irq_id,
    output logic [DATA_WIDTH-1:0] hw_up_irq_pend,
    output logic [DATA_WIDTH-1:0] hw_val_irq_pend
`ifdef IRQ_MISS_FLAG_EN
    ,
    output logic [NUM_SRC-1:0]    irq_miss
`endif
);

    localparam logic [DATA_WIDTH-1:0] c_pend_mask = DATA_WIDTH'({NUM_SRC{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_irq_req;
    logic [ID_W-1:0]       r_irq_id;
    logic [NUM_SRC-1:0]    r_src_q;
    logic [NUM_SRC-1:0]    r_pend;
    logic [DATA_WIDTH-1:0] r_hw_up;

    logic [NUM_SRC-1:0]    w_rise;
    logic [NUM_SRC-1:0]    w_req_vec;
    logic [NUM_SRC-1:0]    w_clr;
    logic [NUM_SRC-1:0]    w_ack_clr;
    logic [ID_W-1:0]       w_sel_id;
    logic                  w_ack_take;
    logic                  w_unused_hi;

    // Only the low NUM_SRC bits of the SFR words carry meaning.
    assign w_unused_hi = ^{irq_en, irq_clr};

    assign w_rise     = src_event & ~r_src_q;
    assign w_req_vec  = r_pend & irq_en[NUM_SRC-1:0];
    assign w_clr      = irq_clr[NUM_SRC-1:0];
    assign w_ack_take = (r_state == S_REQ) && irq_ack;
    assign w_ack_clr  = w_ack_take ? (NUM_SRC'(1) << r_irq_id) : '0;

    // Lowest set index of the masked pending vector wins.
    always_comb begin
        w_sel_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_req_vec[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end

    // Event edge-detect history.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_src_q <= '0;
        end else begin
            r_src_q <= src_event;
        end
    end

    // Sticky pending flags: a new rise beats any clear in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_rise | (r_pend & ~(w_clr | w_ack_clr));
        end
    end

    // Request handshake FSM; request id is frozen until the CPU acks.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_irq_req <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req_vec) begin
                        r_state   <= S_REQ;
                        r_irq_req <= 1'b1;
                        r_irq_id  <= w_sel_id;
                    end
                end
                S_REQ: begin
                    if (irq_ack) begin
                        r_state   <= S_SERVICE;
                        r_irq_req <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (irq_eoi) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_irq_req <= 1'b0;
                end
            endcase
        end
    end

    // SFR update-enable word: held low in reset, then flags the used bits.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_hw_up <= '0;
        end else begin
            r_hw_up <= c_pend_mask;
        end
    end

    assign irq_req         = r_irq_req;
    assign irq_id          = r_irq_id;
    assign hw_up_irq_pend  = r_hw_up;
    assign hw_val_irq_pend = DATA_WIDTH'(r_pend);

`ifdef IRQ_MISS_FLAG_EN
    logic [NUM_SRC-1:0] r_miss;

    // Missed-event flags: a rise on an already pending source; set beats clear.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_miss <= '0;
        end else begin
            r_miss <= (w_rise & r_pend) | (r_miss & ~w_clr);
        end
    end

    assign irq_miss = r_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_nsrc_v1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctrl_nsrc_v1
//  Description : Directed self-checking bench for irq_ctrl_nsrc_v1. Expected
//                request ids are queued when events are driven and popped
//                when the controller raises irq_req.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl_nsrc_v1;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_SRC    = 8;
    localparam int ID_W       = 3;

    logic                  sys_clk;
    logic                  sys_rst_n;
    logic [NUM_SRC-1:0]    src_event;
    logic [DATA_WIDTH-1:0] irq_en;
    logic [DATA_WIDTH-1:0] irq_clr;
    logic                  irq_ack;
    logic                  irq_eoi;
    logic                  irq_req;
    logic [ID_W-1:0]       irq_id;
    logic [DATA_WIDTH-1:0] hw_up_irq_pend;
    logic [DATA_WIDTH-1:0] hw_val_irq_pend;
`ifdef IRQ_MISS_FLAG_EN
    logic [NUM_SRC-1:0]    irq_miss;
`endif

    int total;
    int bad;
    int exp_q[$];

    irq_ctrl_nsrc_v1 #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SRC    (NUM_SRC)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .src_event       (src_event),
        .irq_en          (irq_en),
        .irq_clr         (irq_clr),
        .irq_ack         (irq_ack),
        .irq_eoi         (irq_eoi),
        .irq_req         (irq_req),
        .irq_id          (irq_id),
        .hw_up_irq_pend  (hw_up_irq_pend),
        .hw_val_irq_pend (hw_val_irq_pend)
`ifdef IRQ_MISS_FLAG_EN
        ,
        .irq_miss        (irq_miss)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, then compare its id with the scoreboard head.
    task automatic wait_and_pop(input string tag);
        int n;
        int e;
        n = 0;
        while (irq_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(irq_req), 32'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb_empty observed=id%0d expected=none", tag, irq_id);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_id"}, 32'(irq_id), 32'(e));
        end
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        irq_eoi = 1'b1;
        tick();
        irq_eoi = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        sys_rst_n = 1'b0;
        src_event = '0;
        irq_en    = '0;
        irq_clr   = '0;
        irq_ack   = 1'b0;
        irq_eoi   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req", 32'(irq_req), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_hw_up", hw_up_irq_pend, 32'h0);
        check("rst_hw_val", hw_val_irq_pend, 32'h0);
`ifdef IRQ_MISS_FLAG_EN
        check("rst_miss", 32'(irq_miss), 32'h0);
`endif
        sys_rst_n = 1'b1;
        tick();
        check("hw_up_mask", hw_up_irq_pend, 32'h0000_00FF);

        // 1) single pulse on source 2, latency N+2
        irq_en    = 32'h4;
        src_event = 8'h04;
        exp_q.push_back(2);
        tick();
        src_event = 8'h00;
        check("t1_pend", hw_val_irq_pend, 32'h4);
        check("t1_req_early", 32'(irq_req), 32'd0);
        tick();
        check("t1_req_n2", 32'(irq_req), 32'd1);
        wait_and_pop("t1");
        do_ack();
        check("t1_ack_req", 32'(irq_req), 32'd0);
        check("t1_ack_pend", hw_val_irq_pend, 32'h0);
        do_eoi();
        tick();
        check("t1_idle_req", 32'(irq_req), 32'd0);

        // ack/eoi while idle are ignored
        irq_ack = 1'b1;
        irq_eoi = 1'b1;
        tick();
        irq_ack = 1'b0;
        irq_eoi = 1'b0;
        tick();
        check("stray_ack_req", 32'(irq_req), 32'd0);

        // 2) simultaneous rises on 1 and 3
        irq_en    = 32'hFF;
        src_event = 8'h0A;
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        src_event = 8'h00;
        tick();
        check("t2_pend", hw_val_irq_pend, 32'h0A);
        wait_and_pop("t2a");
        do_ack();
        check("t2_pend_after_ack", hw_val_irq_pend, 32'h08);
        do_eoi();
        check("t2_eoi_req", 32'(irq_req), 32'd0);
        tick();
        check("t2_rereq_m1", 32'(irq_req), 32'd1);
        wait_and_pop("t2b");
        do_ack();
        do_eoi();
        check("t2_pend_end", hw_val_irq_pend, 32'h0);

        // 3) masked source still latches; enabling it raises the request
        irq_en    = 32'h0;
        src_event = 8'h20;
        tick();
        tick();
        tick();
        check("t3_pend", hw_val_irq_pend, 32'h20);
        check("t3_masked_req", 32'(irq_req), 32'd0);
        exp_q.push_back(5);
        irq_en = 32'h20;
        tick();
        check("t3_en_req", 32'(irq_req), 32'd1);
        wait_and_pop("t3");
        do_ack();
        check("t3_held_level_pend", hw_val_irq_pend, 32'h0);
        src_event = 8'h00;
        do_eoi();

        // 4) rise on source 0 in the cycle it is acked
        irq_en    = 32'hFF;
        src_event = 8'h01;
        exp_q.push_back(0);
        tick();
        src_event = 8'h00;
        tick();
        wait_and_pop("t4a");
        exp_q.push_back(0);
        irq_ack   = 1'b1;
        src_event = 8'h01;
        tick();
        irq_ack   = 1'b0;
        src_event = 8'h00;
        check("t4_ack_req", 32'(irq_req), 32'd0);
        check("t4_pend_kept", hw_val_irq_pend, 32'h1);
        do_eoi();
        wait_and_pop("t4b");
        do_ack();
        do_eoi();
        check("t4_pend_end", hw_val_irq_pend, 32'h0);

        // 5) set beats clear; plain clear; reset while in REQ
        irq_en    = 32'h0;
        irq_clr   = 32'h10;
        src_event = 8'h10;
        tick();
        irq_clr   = 32'h0;
        src_event = 8'h00;
        check("t5_set_wins", hw_val_irq_pend, 32'h10);
        irq_clr = 32'h10;
        tick();
        irq_clr = 32'h0;
        check("t5_clr", hw_val_irq_pend, 32'h0);
        irq_en    = 32'hFF;
        src_event = 8'h10;
        exp_q.push_back(4);
        tick();
        src_event = 8'h00;
        tick();
        wait_and_pop("t5");
        sys_rst_n = 1'b0;
        tick();
        check("t5_rst_req", 32'(irq_req), 32'd0);
        check("t5_rst_pend", hw_val_irq_pend, 32'h0);
        check("t5_rst_hw_up", hw_up_irq_pend, 32'h0);
        sys_rst_n = 1'b1;
        tick();
        tick();
        check("t5_post_rst_req", 32'(irq_req), 32'd0);

`ifdef IRQ_MISS_FLAG_EN
        // 6) repeated event on a pending source flags a miss
        irq_en    = 32'h0;
        src_event = 8'h40;
        tick();
        src_event = 8'h00;
        tick();
        check("t6_miss_first", 32'(irq_miss), 32'h0);
        src_event = 8'h40;
        tick();
        src_event = 8'h00;
        check("t6_miss_set", 32'(irq_miss), 32'h40);
        check("t6_pend", hw_val_irq_pend, 32'h40);
        irq_clr = 32'h40;
        tick();
        irq_clr = 32'h0;
        check("t6_clr_pend", hw_val_irq_pend, 32'h0);
        check("t6_clr_miss", 32'(irq_miss), 32'h0);
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
